pump_duty_meter: RTL and testbench



---
 rtl/pump_duty_meter_if.sv | 22 ++
 rtl/pump_duty_meter.sv | 109 ++++++++++
 tb/tb_pump_duty_meter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pump_duty_meter_if.sv
// pump_duty_meter_if: pump/enable stimulus and per-window measurement results
//   master: drives pump_in, enable; observes the report outputs
//   slave : the meter; samples pump_in, enable; drives the report outputs
interface pump_duty_meter_if;
  logic pump_in;
  logic enable;
  logic [15:0] duty_out;
  logic signed [16:0] duty_delta;
  logic [15:0] edge_count;
  logic duty_valid;
  logic stuck_high;
  logic stuck_low;
  logic locked;
  modport master (
    output pump_in, enable,
    input duty_out, duty_delta, edge_count, duty_valid, stuck_high, stuck_low, locked
  );
  modport slave (
    input pump_in, enable,
    output duty_out, duty_delta, edge_count, duty_valid, stuck_high, stuck_low, locked
  );
endinterface

// File: rtl/pump_duty_meter.sv
// pump_duty_meter: synchronises the charge-pump bitstream and reports duty, delta, edges, stuck and lock per window
//   pwm_clk_in : sample clock (rising edge)
//   reset_in   : asynchronous active-high reset
//   bus.slave  : pump_in/enable in; duty_out, duty_delta, edge_count, duty_valid, stuck_high, stuck_low, locked out
module pump_duty_meter #(
  parameter int WINDOW = 60000,
  parameter int SYNC_STAGES = 2,
  parameter int TOL = 4,
  parameter int LOCK_COUNT = 8
) (
  input logic pwm_clk_in,
  input logic reset_in,
  pump_duty_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FLUSH, MEASURE, REPORT} state_t;
  localparam logic signed [16:0] TOL_S = 17'(TOL);
  localparam logic [15:0] LC = 16'(LOCK_COUNT);
  state_t state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic ps_prev_q, first_q, valid_q, stuck_h_q, stuck_l_q, locked_q;
  logic [1:0] flush_cnt_q;
  logic [15:0] sample_cnt_q, high_cnt_q, edge_cnt_q, stable_cnt_q, duty_q, edges_q;
  logic signed [16:0] delta_q, delta_d;
  logic ps, rise, stuck_h_d, stuck_l_d, abort, in_tol;
  logic [15:0] stable_d;
  always_comb begin
    ps = sync_q[SYNC_STAGES-1];
    rise = ps & ~ps_prev_q;
    abort = (state_q == FLUSH || state_q == MEASURE) && !bus.enable;
    stuck_h_d = high_cnt_q == 16'(WINDOW);
    stuck_l_d = high_cnt_q == 16'd0;
    delta_d = first_q ? 17'sd0 : $signed({1'b0, high_cnt_q}) - $signed({1'b0, duty_q});
    in_tol = delta_d <= TOL_S && delta_d >= -TOL_S && !stuck_h_d && !stuck_l_d;
    // the first report after enable has no valid predecessor, so it leaves the lock history alone
    stable_d = first_q ? stable_cnt_q : !in_tol ? 16'd0 : stable_cnt_q >= LC ? LC : stable_cnt_q + 16'd1;
  end
  always_ff @(posedge pwm_clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      sync_q <= '0;
      ps_prev_q <= 1'b0;
      first_q <= 1'b1;
      flush_cnt_q <= '0;
      sample_cnt_q <= '0;
      high_cnt_q <= '0;
      edge_cnt_q <= '0;
      stable_cnt_q <= '0;
      duty_q <= '0;
      edges_q <= '0;
      delta_q <= '0;
      valid_q <= 1'b0;
      stuck_h_q <= 1'b0;
      stuck_l_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pump_in};
      ps_prev_q <= ps;
      valid_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        sample_cnt_q <= '0;
        high_cnt_q <= '0;
        edge_cnt_q <= '0;
        stable_cnt_q <= '0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (bus.enable) begin
            state_q <= FLUSH;
            flush_cnt_q <= '0;
            first_q <= 1'b1;
          end
          FLUSH: begin
            flush_cnt_q <= flush_cnt_q + 2'd1;
            if (flush_cnt_q == 2'(SYNC_STAGES - 1)) state_q <= MEASURE;
          end
          MEASURE: begin
            sample_cnt_q <= sample_cnt_q + 16'd1;
            high_cnt_q <= high_cnt_q + 16'(ps);
            edge_cnt_q <= edge_cnt_q + 16'(rise);
            if (sample_cnt_q == 16'(WINDOW - 1)) state_q <= REPORT;
          end
          default: begin
            duty_q <= high_cnt_q;
            edges_q <= edge_cnt_q;
            delta_q <= delta_d;
            stuck_h_q <= stuck_h_d;
            stuck_l_q <= stuck_l_d;
            stable_cnt_q <= stable_d;
            locked_q <= stable_d >= LC;
            valid_q <= 1'b1;
            first_q <= 1'b0;
            sample_cnt_q <= '0;
            high_cnt_q <= '0;
            edge_cnt_q <= '0;
            state_q <= bus.enable ? MEASURE : IDLE;
          end
        endcase
      end
    end
  end
  assign bus.duty_out = duty_q;
  assign bus.duty_delta = delta_q;
  assign bus.edge_count = edges_q;
  assign bus.duty_valid = valid_q;
  assign bus.stuck_high = stuck_h_q;
  assign bus.stuck_low = stuck_l_q;
  assign bus.locked = locked_q;
endmodule

// File: tb/tb_pump_duty_meter.sv
// tb_pump_duty_meter: scoreboard bench for pump_duty_meter (WINDOW=16, SYNC_STAGES=2, TOL=1, LOCK_COUNT=3)
`timescale 1ns/1ns
module tb_pump_duty_meter;
  typedef struct packed {
    logic [15:0] duty;
    logic [15:0] edges;
    logic signed [16:0] delta;
    logic sh;
    logic sl;
    logic lk;
  } rpt_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  pump_duty_meter_if bus ();
  pump_duty_meter #(.WINDOW(16), .SYNC_STAGES(2), .TOL(1), .LOCK_COUNT(3)) dut (
    .pwm_clk_in(clk),
    .reset_in(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  logic [7:0] pat = 8'h00;
  int pat_len = 1;
  int idx = 0;
  logic pump_pat = 1'b0;
  logic pump_async = 1'b0;
  bit drv_en = 1'b1;
  always @(negedge clk) begin
    pump_pat = pat[idx % pat_len];
    idx = idx + 1;
  end
  assign bus.pump_in = drv_en ? pump_pat : pump_async;
  int vectors = 0;
  int miscompares = 0;
  rpt_t exp_q[$];
  int m_prev = 0;
  int m_stable = 0;
  bit m_first = 1'b1;
  task automatic push_exp(input int duty, input int edges);
    rpt_t e;
    int d;
    d = m_first ? 0 : duty - m_prev;
    e.duty = 16'(duty);
    e.edges = 16'(edges);
    e.delta = 17'(d);
    e.sh = duty == 16;
    e.sl = duty == 0;
    if (!m_first) m_stable = (d >= -1 && d <= 1 && !e.sh && !e.sl) ? (m_stable < 3 ? m_stable + 1 : 3) : 0;
    e.lk = m_stable >= 3;
    m_first = 1'b0;
    m_prev = duty;
    exp_q.push_back(e);
  endtask
  function automatic rpt_t observed();
    return {bus.duty_out, bus.edge_count, bus.duty_delta, bus.stuck_high, bus.stuck_low, bus.locked};
  endfunction
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 60 && n < 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.duty_valid === 1'b1) n = i;
    end
  endtask
  task automatic start();
    @(posedge clk);
    #1;
    bus.enable = 1'b1;
    m_first = 1'b1;
    @(posedge clk);
  endtask
  task automatic stop();
    bus.enable = 1'b0;
    m_stable = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rpt_t o;
    bus.enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = observed();
    vectors++;
    if (o !== '0 || bus.duty_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h valid %b want 0", o, bus.duty_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    o = observed();
    vectors++;
    if (o !== '0 || bus.duty_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got %h valid %b want 0", o, bus.duty_valid);
    end
  endtask
  task automatic test_stuck_high();
    int n;
    rpt_t e, o;
    pat = 8'h01;
    pat_len = 1;
    repeat (6) @(posedge clk);
    start();
    repeat (3) push_exp(16, 0);
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      e = exp_q.pop_front();
      o = observed();
      vectors++;
      if (n < 0 || o !== e) begin
        miscompares++;
        $display("FAIL stuck_high[%0d]: got %h (wait %0d) want %h", i, o, n, e);
      end
    end
    stop();
  endtask
  task automatic test_pattern25();
    int n;
    rpt_t e, o;
    pat = 8'b0001;
    pat_len = 4;
    repeat (4) @(posedge clk);
    start();
    repeat (4) push_exp(4, 4);
    for (int i = 0; i < 4; i++) begin
      wait_valid(n);
      vectors++;
      if (n != (i == 0 ? 19 : 17)) begin
        miscompares++;
        $display("FAIL latency25[%0d]: got %0d cycles want %0d", i, n, i == 0 ? 19 : 17);
      end
      e = exp_q.pop_front();
      o = observed();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL pattern25[%0d]: got %h want %h", i, o, e);
      end
    end
  endtask
  task automatic test_abort();
    bit seen;
    repeat (5) @(posedge clk);
    #1;
    bus.enable = 1'b0;
    m_stable = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      seen = seen | (bus.duty_valid === 1'b1);
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL abort_valid: got a duty_valid pulse want none");
    end
    vectors++;
    if (bus.locked !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_locked: got %b want 0", bus.locked);
    end
    vectors++;
    if (bus.duty_out !== 16'd4) begin
      miscompares++;
      $display("FAIL abort_duty_hold: got %0d want 4", bus.duty_out);
    end
  endtask
  task automatic test_unlock();
    int n;
    rpt_t e, o;
    start();
    repeat (5) push_exp(4, 4);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        // the new pattern reaches the sampler after the last sample of window 5
        repeat (14) @(posedge clk);
        #1;
        pat = 8'b01;
        pat_len = 2;
        push_exp(8, 8);
      end
      wait_valid(n);
      e = exp_q.pop_front();
      o = observed();
      vectors++;
      if (n < 0 || o !== e) begin
        miscompares++;
        $display("FAIL unlock[%0d]: got %h (wait %0d) want %h", i, o, n, e);
      end
    end
    stop();
  endtask
  task automatic test_reset_mid();
    int n;
    rpt_t e, o;
    start();
    repeat (8) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    o = observed();
    vectors++;
    if (o !== '0 || bus.duty_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h valid %b want 0", o, bus.duty_valid);
    end
    bus.enable = 1'b0;
    m_prev = 0;
    m_stable = 0;
    m_first = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start();
    push_exp(8, 8);
    wait_valid(n);
    vectors++;
    if (n != 19) begin
      miscompares++;
      $display("FAIL reset_latency: got %0d cycles want 19", n);
    end
    e = exp_q.pop_front();
    o = observed();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL reset_report: got %h want %h", o, e);
    end
    stop();
  endtask
  task automatic test_async();
    int a[3], len[3];
    int lq[$];
    longint t0;
    drv_en = 1'b0;
    pump_async = 1'b0;
    for (int w = 0; w < 3; w++) begin
      a[w] = $urandom_range(12, 38);
      if (a[w] % 10 == 5) a[w]++;
      len[w] = $urandom_range(15, 95);
      if ((a[w] + len[w]) % 10 == 5) len[w]++;
      lq.push_back(len[w]);
    end
    repeat (4) @(posedge clk);
    start();
    t0 = $time;
    fork
      begin
        for (int w = 0; w < 3; w++) begin
          #(t0 + 170 * w + a[w] - $time);
          pump_async = 1'b1;
          #(len[w]);
          pump_async = 1'b0;
        end
      end
      begin
        int n, l;
        for (int w = 0; w < 3; w++) begin
          wait_valid(n);
          l = lq.pop_front();
          vectors++;
          if (n < 0 || $isunknown(observed()) || 10 * int'(bus.duty_out) > l + 10 || 10 * int'(bus.duty_out) < l - 10) begin
            miscompares++;
            $display("FAIL async_duty[%0d]: got %0d (wait %0d) want %0d/10 +-1", w, bus.duty_out, n, l);
          end
          vectors++;
          if (bus.edge_count !== 16'd1) begin
            miscompares++;
            $display("FAIL async_edges[%0d]: got %0d want 1", w, bus.edge_count);
          end
        end
      end
    join
    stop();
    drv_en = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.enable = 1'b0;
    test_reset();
    test_stuck_high();
    test_pattern25();
    test_abort();
    test_unlock();
    test_reset_mid();
    test_async();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
